// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider (RNE, flush-to-zero), start/done handshake.
// Optional exception flags port enabled by defining FDIV_EXC_FLAGS_EN.
module fdiv_iter #(
    parameter int unsigned QBITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
`ifdef FDIV_EXC_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam int unsigned N     = 26 / QBITS_PER_CYCLE;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned REM_W = 26;
    localparam int unsigned QUO_W = 26;
    localparam int unsigned EXP_W = 10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND} state_t;
    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d, rem_t;
    logic [QUO_W-1:0]   quo_q, quo_d, quo_t;
    logic [23:0]        mb_q, mb_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;

    // Operand classification on the raw inputs (exp==0 is zero, subnormals flushed)
    logic [7:0]  e1, e2;
    logic [23:0] ma, mb;
    logic z1, z2, i1, i2, n1, n2, adj;
    assign e1  = op1[30:23];
    assign e2  = op2[30:23];
    assign ma  = {1'b1, op1[22:0]};
    assign mb  = {1'b1, op2[22:0]};
    assign z1  = (e1 == 8'h00);
    assign z2  = (e2 == 8'h00);
    assign i1  = (e1 == 8'hFF) && (op1[22:0] == 23'h0);
    assign i2  = (e2 == 8'hFF) && (op2[22:0] == 23'h0);
    assign n1  = (e1 == 8'hFF) && (op1[22:0] != 23'h0);
    assign n2  = (e2 == 8'hFF) && (op2[22:0] != 23'h0);
    assign adj = (ma < mb);

`ifdef FDIV_EXC_FLAGS_EN
    logic       inv_q, inv_d, dbz_q, dbz_d;
    logic [3:0] flags_q, flags_d;
    assign flags = flags_q;
`endif

    // Restoring division, QBITS_PER_CYCLE steps per clock
    always_comb begin
        rem_t = rem_q;
        quo_t = quo_q;
        for (int i = 0; i < int'(QBITS_PER_CYCLE); i++) begin
            if (rem_t >= {2'b00, mb_q}) begin
                rem_t = rem_t - {2'b00, mb_q};
                quo_t = {quo_t[QUO_W-2:0], 1'b1};
            end else begin
                quo_t = {quo_t[QUO_W-2:0], 1'b0};
            end
            rem_t = {rem_t[REM_W-2:0], 1'b0};
        end
    end

    // Round-to-nearest-even and range check of the finished quotient
    logic        sticky, inc, rnd_ovf, rnd_unf;
    logic [24:0] mant_r;
    logic [EXP_W-1:0] exp_r;
    logic [31:0] rnd_res;
    always_comb begin
        sticky  = (rem_q != '0);
        inc     = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
        mant_r  = {1'b0, quo_q[25:2]} + 25'(inc);
        exp_r   = exp_q + EXP_W'(mant_r[24]);
        rnd_ovf = 1'b0;
        rnd_unf = 1'b0;
        if ($signed(exp_r) > $signed(10'sd254)) begin
            rnd_res = {sign_q, 8'hFF, 23'h0};
            rnd_ovf = 1'b1;
        end else if ($signed(exp_r) < $signed(10'sd1)) begin
            rnd_res = {sign_q, 31'h0};
            rnd_unf = 1'b1;
        end else begin
            rnd_res = {sign_q, exp_r[7:0], mant_r[22:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef FDIV_EXC_FLAGS_EN
        inv_d    = inv_q;
        dbz_d    = dbz_q;
        flags_d  = flags_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    sign_d  = op1[31] ^ op2[31];
                    mb_d    = mb;
                    quo_d   = '0;
                    rem_d   = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
                    exp_d   = EXP_W'(e1) - EXP_W'(e2) + EXP_W'(127) - EXP_W'(adj);
                    if (n1 || n2 || (z1 && z2) || (i1 && i2)) kind_d = K_NAN;
                    else if (z2 || i1)                        kind_d = K_INF;
                    else if (z1 || i2)                        kind_d = K_ZERO;
                    else                                      kind_d = K_NORM;
`ifdef FDIV_EXC_FLAGS_EN
                    inv_d = n1 || n2 || (z1 && z2) || (i1 && i2);
                    dbz_d = z2 && !z1 && !i1 && !n1;
`endif
                end
            end
            S_CALC: begin
                busy_d = 1'b1;
                rem_d  = rem_t;
                quo_d  = quo_t;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (kind_q)
                    K_NAN:   result_d = 32'h7FC00000;
                    K_INF:   result_d = {sign_q, 8'hFF, 23'h0};
                    K_ZERO:  result_d = {sign_q, 31'h0};
                    default: result_d = rnd_res;
                endcase
`ifdef FDIV_EXC_FLAGS_EN
                flags_d = {inv_q, dbz_q,
                           (kind_q == K_NORM) && rnd_ovf,
                           (kind_q == K_NORM) && rnd_unf};
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            kind_q   <= K_NORM;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mb_q     <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'h0;
`ifdef FDIV_EXC_FLAGS_EN
            inv_q    <= 1'b0;
            dbz_q    <= 1'b0;
            flags_q  <= 4'b0;
`endif
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef FDIV_EXC_FLAGS_EN
            inv_q    <= inv_d;
            dbz_q    <= dbz_d;
            flags_q  <= flags_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed vectors, handshake corner cases and
// random operands against an exact-integer division model. Flags checked when FDIV_EXC_FLAGS_EN is defined.
module tb_fdiv_iter;

    localparam int unsigned Q   = 1;
    localparam int unsigned N   = 26 / Q;
    localparam int unsigned TMO = N + 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] op1, op2, result;
    logic        busy, done;
`ifdef FDIV_EXC_FLAGS_EN
    logic [3:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fdiv_iter #(.QBITS_PER_CYCLE(Q)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef FDIV_EXC_FLAGS_EN
        ,
        .flags  (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] get_flags();
`ifdef FDIV_EXC_FLAGS_EN
        return flags;
`else
        return 4'b0;
`endif
    endfunction

    // Reference: exact integer quotient of the significands, then IEEE RNE, returns {flags, result}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic        za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, qt, rm, keep, low, half;
        int          sh, e;
        bit          up;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib)) return {4'b1000, 32'h7FC00000};
        if (zb) return {(ia ? 4'b0000 : 4'b0100), s, 8'hFF, 23'h0};
        if (ia) return {4'b0000, s, 8'hFF, 23'h0};
        if (za || ib) return {4'b0000, s, 31'h0};
        ma = 64'(1 << 23) | 64'(a[22:0]);
        mb = 64'(1 << 23) | 64'(b[22:0]);
        qt = (ma << 38) / mb;
        rm = (ma << 38) % mb;
        e  = int'(ea) - int'(eb) + 127;
        if (ma >= mb) sh = 15;
        else begin sh = 14; e = e - 1; end
        keep = qt >> sh;
        low  = qt & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (low > half) || ((low == half) && ((rm != 0) || keep[0]));
        keep = keep + 64'(up);
        if (keep == (64'd1 << 24)) begin keep = 64'd1 << 23; e = e + 1; end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0001, s, 31'h0};
        return {4'b0000, s, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] gen_op();
        int unsigned r;
        logic [7:0]  ex;
        logic [22:0] fr;
        r  = $urandom_range(0, 15);
        fr = 23'($urandom());
        case (r)
            0:       ex = 8'h00;
            1:       begin ex = 8'hFF; fr = 23'h0; end
            2:       begin ex = 8'hFF; fr = fr | 23'h1; end
            3:       ex = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(246, 254));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom()), ex, fr};
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output int bcyc);
        @(negedge clk);
        op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op1 = $urandom(); op2 = $urandom();
        lat = 0; bcyc = 0;
        while (lat < int'(TMO)) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcyc++;
            if (done) break;
        end
        res = result;
        flg = get_flags();
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic [3:0] exp_flg);
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat, bcyc;
        do_div(a, b, res, flg, lat, bcyc);
        check({tag, "_latency"}, 64'(lat), 64'(N + 1));
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(N));
        check({tag, "_result"}, 64'(res), 64'(exp_res));
`ifdef FDIV_EXC_FLAGS_EN
        check({tag, "_flags"}, 64'(flg), 64'(exp_flg));
`else
        if (flg != exp_flg && 1'b0) $display("unused");
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t dir[] = '{
        '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000},
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000},
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000},
        '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100},
        '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000},
        '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010},
        '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001},
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000},
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000},
        '{32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000},
        '{32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000},
        '{32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000},
        '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000}
    };

    initial begin
        logic [35:0] m;
        logic [31:0] a, b;
        int          lat, ndone;

        reset = 1'b1; start = 1'b0; op1 = '0; op2 = '0;
        #2 reset = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'(result), 64'(0));
`ifdef FDIV_EXC_FLAGS_EN
        check("reset_flags", 64'(flags), 64'(0));
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (dir[i]) run_check($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].r, dir[i].f);

        // Start pulses while busy are ignored; a start in the done cycle is accepted
        @(negedge clk);
        op1 = 32'h3F800000; op2 = 32'h3F800000; start = 1'b1;
        @(posedge clk); #1;
        lat = 0; ndone = 0;
        while (lat < int'(TMO) && ndone == 0) begin
            @(negedge clk);
            op1 = $urandom(); op2 = $urandom(); start = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (done) ndone++;
        end
        check("busy_start_latency", 64'(lat), 64'(N + 1));
        check("busy_start_result", 64'(result), 64'h3F800000);
        @(negedge clk);
        op1 = 32'h40C00000; op2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < int'(TMO)) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check("done_cycle_start_latency", 64'(lat), 64'(N + 1));
        check("done_cycle_start_result", 64'(result), 64'h40400000);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        op1 = 32'h3F800000; op2 = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N / 2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_result", 64'(result), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'(0));
        run_check("after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            a = gen_op();
            b = gen_op();
            m = model(a, b);
            run_check($sformatf("rnd%0d_%h_%h", i, a, b), a, b, m[31:0], m[35:32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
